serial_to_parallel: RTL

//   Receive-side byte deserializer for the UART link to the RSA core.
//   - Collects N/8 bytes from the UART receiver, MSB byte first, into one N-bit operand word.
//   - Presents the word downstream with a valid/ready handshake.
//   - Same byte order as the transmit-side serializer: the first byte received lands in word[N-1:N-8].

---
 rtl/rsa_uart_pkg.sv | 7 +
 rtl/serial_to_parallel_if.sv | 24 ++
 rtl/s2p_timeout_timer.sv | 23 ++
 rtl/serial_to_parallel.sv | 91 +++++++++
 4 files changed

// File: rtl/rsa_uart_pkg.sv
// rsa_uart_pkg: shared types and defaults for the RSA UART link
package rsa_uart_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;
  localparam int BYTE_W = 8;
  localparam int DEF_N = 256;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;
endpackage

// File: rtl/serial_to_parallel_if.sv
// serial_to_parallel_if: byte-in / word-out handshake bundle for the deserializer
//   master drives rx_valid, rx_byte, word_ready; slave (the deserializer) drives the rest
interface serial_to_parallel_if
  import rsa_uart_pkg::*;
#(
  parameter int N = DEF_N
);
  logic rx_valid;
  logic [BYTE_W-1:0] rx_byte;
  logic word_ready;
  logic word_valid;
  logic [N-1:0] word;
  logic busy;
  logic overrun;
  logic timeout;
  modport master (
    output rx_valid, rx_byte, word_ready,
    input word_valid, word, busy, overrun, timeout
  );
  modport slave (
    input rx_valid, rx_byte, word_ready,
    output word_valid, word, busy, overrun, timeout
  );
endinterface

// File: rtl/s2p_timeout_timer.sv
// s2p_timeout_timer: counts idle cycles while run is high and flags expiry
//   clk, rst : clock and synchronous active-high reset
//   clear    : a byte arrived this cycle, restart the count
//   run      : deserializer is collecting a partial word
//   expired  : LIMIT idle cycles have elapsed with no clear
module s2p_timeout_timer
  import rsa_uart_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clear || !run) ? '0 : cnt + W'(1);
  // a byte in the expiry cycle wins over the timeout
  assign expired = run && !clear && cnt == W'(LIMIT - 1);
endmodule

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: assembles N/8 UART bytes, MSB byte first, into one N-bit word
//   clk, rst : clock and synchronous active-high reset
//   s        : slave modport of serial_to_parallel_if (rx_valid/rx_byte in, word_valid/word
//              out with word_ready handshake, busy, overrun and timeout pulses)
//   Define S2P_TIMEOUT_EN to discard partial words after TIMEOUT_CYCLES idle cycles.
module serial_to_parallel
  import rsa_uart_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int CNT_W = 6,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic clk,
  input logic rst,
  serial_to_parallel_if.slave s
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N / BYTE_W - 1);
  if (N % BYTE_W != 0 || N < 16 || (2 ** CNT_W) <= N / BYTE_W || TIMEOUT_CYCLES < 1) begin : g_bad
    $error("serial_to_parallel: illegal parameter combination");
  end
  state_t state;
  logic [N-1:0] sr;
  logic [CNT_W-1:0] count;
  logic word_valid, busy, overrun, timeout, expired;
  logic [N-1:0] shifted;
  assign shifted = {sr[N-BYTE_W-1:0], s.rx_byte};
`ifdef S2P_TIMEOUT_EN
  s2p_timeout_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(s.rx_valid),
    .run(state == COLLECT),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      count <= '0;
      word_valid <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: if (s.rx_valid) begin
          sr <= shifted;
          count <= CNT_W'(1);
          state <= COLLECT;
          busy <= 1'b1;
        end
        COLLECT: if (s.rx_valid) begin
          sr <= shifted;
          count <= (count == LAST) ? '0 : count + CNT_W'(1);
          if (count == LAST) begin
            state <= FULL;
            word_valid <= 1'b1;
            busy <= 1'b0;
          end
        end else if (expired) begin
          sr <= '0;
          count <= '0;
          state <= IDLE;
          busy <= 1'b0;
          timeout <= 1'b1;
        end
        FULL: if (s.word_ready) begin
          // a byte arriving with the transfer starts the next word
          word_valid <= 1'b0;
          state <= s.rx_valid ? COLLECT : IDLE;
          busy <= s.rx_valid;
          if (s.rx_valid) begin
            sr <= shifted;
            count <= CNT_W'(1);
          end
        end else if (s.rx_valid) overrun <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
  assign s.word_valid = word_valid;
  assign s.word = sr;
  assign s.busy = busy;
  assign s.overrun = overrun;
  assign s.timeout = timeout;
endmodule
